// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl
//   Sequencer between the EXE stage and the external two-cycle multiplier.
//   It owns the architectural HI/LO registers. It accepts multiply and HI/LO
//   move requests, launches operands to the multiplier, and stalls EXE while
//   a multiply is in flight. It returns MFHI/MFLO data one cycle after the
//   request is accepted.
//
// Ports
//   clk, resetn              clock and asynchronous active-low reset
//   flush                    cancels an in-flight multiply and blocks acceptance
//   req_valid / req_ready    request handshake from EXE
//   req_op, req_a, req_b     opcode (0 MULT, 1 MULTU, 2 MFHI, 3 MFLO, 4 MTHI, 5 MTLO)
//                            and operands
//   resp_valid / resp_data   one-cycle MFHI/MFLO response
//   busy                     multiply in flight
//   mul_signed, mul_x, mul_y operands driven to the multiplier
//   mul_result               64-bit product returned by the multiplier, {HI,LO}
//   hi_o, lo_o               current HI and LO

module hilo_mul_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_result,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MFHI  = 3'd2;
  localparam logic [2:0] OP_MFLO  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [31:0] op_x_q, op_x_d;
  logic signed [31:0] op_y_q, op_y_d;
  logic               op_signed_q, op_signed_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_data_q, resp_data_d;
  logic               accept;

  // Gated with resetn so nothing looks acceptable while reset is asserted.
  assign req_ready = resetn & (state_q == S_IDLE) & ~flush;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_x_d       = op_x_q;
    op_y_d       = op_y_q;
    op_signed_d  = op_signed_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MULT, OP_MULTU: begin
              op_x_d      = req_a;
              op_y_d      = req_b;
              op_signed_d = (req_op == OP_MULT);
              cnt_d       = CNT_W'(MUL_LAT);
              state_d     = S_MUL;
            end
            OP_MFHI: begin
              resp_valid_d = 1'b1;
              resp_data_d  = hi_q;
            end
            OP_MFLO: begin
              resp_valid_d = 1'b1;
              resp_data_d  = lo_q;
            end
            OP_MTHI: hi_d = req_a;
            OP_MTLO: lo_d = req_a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        // cnt counts the edges until the multiplier has registered its
        // product; the edge after it reaches zero captures the result.
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          hi_d    = mul_result[63:32];
          lo_d    = mul_result[31:0];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_x_q       <= '0;
      op_y_q       <= '0;
      op_signed_q  <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_x_q       <= op_x_d;
      op_y_q       <= op_y_d;
      op_signed_q  <= op_signed_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign busy       = (state_q == S_MUL);
  assign mul_signed = op_signed_q;
  assign mul_x      = op_x_q;
  assign mul_y      = op_y_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
module tb_hilo_mul_ctrl;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        busy;
  logic        mul_signed;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic [63:0] mul_result;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;

  hilo_mul_ctrl #(.MUL_LAT(1)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
    .mul_signed(mul_signed), .mul_x(mul_x), .mul_y(mul_y),
    .mul_result(mul_result), .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: registers the full product one edge after sampling.
  logic signed [63:0] sx, sy;
  always_comb begin
    sx = mul_signed ? {{32{mul_x[31]}}, mul_x} : {32'd0, mul_x};
    sy = mul_signed ? {{32{mul_y[31]}}, mul_y} : {32'd0, mul_y};
  end
  always @(posedge clk or negedge resetn) begin
    if (!resetn) mul_result <= '0;
    else         mul_result <= sx * sy;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = v;
    req_op    = op;
    req_a     = a;
    req_b     = b;
  endtask

  initial begin
    resetn = 1'b0;
    flush  = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    #2;
    check("rst_ready", {63'd0, req_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_data", {32'd0, resp_data}, 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    tick();
    resetn = 1'b1;
    tick();

    // 1. MULT -3 * 5
    drive(1'b1, 3'd0, 32'hFFFFFFFD, 32'h00000005);
    check("t1_ready", {63'd0, req_ready}, 64'd1);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    check("t1_busy_c1", {63'd0, busy}, 64'd1);
    check("t1_mul_x", {32'd0, mul_x}, 64'h00000000FFFFFFFD);
    check("t1_mul_signed", {63'd0, mul_signed}, 64'd1);
    tick();
    check("t1_busy_c2", {63'd0, busy}, 64'd1);
    check("t1_hilo_pre", {hi_o, lo_o}, 64'd0);
    tick();
    check("t1_busy_done", {63'd0, busy}, 64'd0);
    check("t1_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFF1);

    // 2. MULTU and MULT of all-ones
    drive(1'b1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    check("t2_multu_signed", {63'd0, mul_signed}, 64'd0);
    tick(); tick();
    check("t2_multu", {hi_o, lo_o}, 64'hFFFFFFFE_00000001);
    drive(1'b1, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    tick(); tick();
    check("t2_mult", {hi_o, lo_o}, 64'h00000000_00000001);

    // 3. MULT 7*6 with MFHI held valid from E1
    drive(1'b1, 3'd0, 32'd7, 32'd6);
    tick();                                   // E0
    drive(1'b1, 3'd2, 32'd0, 32'd0);
    check("t3_ready_e1", {63'd0, req_ready}, 64'd0);
    tick();                                   // E1
    check("t3_ready_e2", {63'd0, req_ready}, 64'd0);
    check("t3_no_resp_e1", {63'd0, resp_valid}, 64'd0);
    tick();                                   // E2
    check("t3_ready_e3", {63'd0, req_ready}, 64'd1);
    check("t3_no_resp_e2", {63'd0, resp_valid}, 64'd0);
    tick();                                   // E3: MFHI accepted
    check("t3_mfhi_valid", {63'd0, resp_valid}, 64'd1);
    check("t3_mfhi_data", {32'd0, resp_data}, 64'd0);
    drive(1'b1, 3'd3, 32'd0, 32'd0);
    tick();
    check("t3_mflo_valid", {63'd0, resp_valid}, 64'd1);
    check("t3_mflo_data", {32'd0, resp_data}, 64'h2A);
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    tick();
    check("t3_resp_pulse", {63'd0, resp_valid}, 64'd0);

    // 4. MTLO then MFLO
    drive(1'b1, 3'd5, 32'h12345678, 32'd0);
    tick();
    check("t4_mtlo_no_resp", {63'd0, resp_valid}, 64'd0);
    check("t4_lo", {hi_o, lo_o}, 64'h00000000_12345678);
    drive(1'b1, 3'd3, 32'd0, 32'd0);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    check("t4_mflo_valid", {63'd0, resp_valid}, 64'd1);
    check("t4_mflo_data", {32'd0, resp_data}, 64'h12345678);

    // Reserved op: accepted, no effect
    drive(1'b1, 3'd6, 32'hDEADBEEF, 32'd0);
    check("rsv_ready", {63'd0, req_ready}, 64'd1);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    check("rsv_no_resp", {63'd0, resp_valid}, 64'd0);
    check("rsv_busy", {63'd0, busy}, 64'd0);
    check("rsv_hilo", {hi_o, lo_o}, 64'h00000000_12345678);

    // 5. preload AAAAAAAA, MULT 2*3 flushed in first MUL cycle
    drive(1'b1, 3'd4, 32'hAAAAAAAA, 32'd0);
    tick();
    drive(1'b1, 3'd5, 32'hAAAAAAAA, 32'd0);
    tick();
    check("t5_preload", {hi_o, lo_o}, 64'hAAAAAAAA_AAAAAAAA);
    drive(1'b1, 3'd0, 32'd2, 32'd3);
    tick();                                   // E0
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    flush = 1'b1;
    check("t5_ready_flush", {63'd0, req_ready}, 64'd0);
    tick();                                   // E1
    flush = 1'b0;
    check("t5_idle", {63'd0, busy}, 64'd0);
    tick();                                   // E2
    check("t5_hilo", {hi_o, lo_o}, 64'hAAAAAAAA_AAAAAAAA);
    // MTHI during flush is not accepted
    flush = 1'b1;
    drive(1'b1, 3'd4, 32'h11111111, 32'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    check("t5_flush_mthi", {hi_o, lo_o}, 64'hAAAAAAAA_AAAAAAAA);

    // 6. asynchronous reset mid-MUL
    drive(1'b1, 3'd0, 32'd2, 32'd3);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    check("t6_busy_pre", {63'd0, busy}, 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_hilo", {hi_o, lo_o}, 64'd0);
    check("t6_rst_busy", {63'd0, busy}, 64'd0);
    check("t6_rst_ready", {63'd0, req_ready}, 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    drive(1'b1, 3'd0, 32'd2, 32'd3);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    tick(); tick();
    check("t6_after_rst", {hi_o, lo_o}, 64'h00000000_00000006);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
